tube_driver: RTL

Memory-mapped output peripheral driving two 4-digit common-anode seven-segment tubes from a 32-bit value written by the CPU through the bridge. It is the output-side counterpart of the key input peripheral: the CPU stores to the data register, and the block time-multiplexes the eight hex digits onto active-low segment and select pins. It holds a data register and a control register, a scan-rate prescaler and a digit-scan counter. All outputs to the pins are registered.

---
 rtl/tube_pkg.sv | 34 +++
 rtl/tube_driver_if.sv | 22 ++
 rtl/hex_to_seg.sv | 15 +
 rtl/tube_driver.sv | 115 +++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// ---------------------------------------------------------------------------
// tube_pkg
// Shared constants for the seven-segment tube driver:
//   SEG_CODE  - active-low segment codes for hex digits 0..F (dp off, bit 7 = 1)
//   OFS_DATA / OFS_CTRL - register byte offsets (0x0 / 0x4)
//   ADDR_DATA / ADDR_CTRL - the one-bit register select derived from them
//   SEG_OFF / SEL_OFF - blank pin levels
//   sel_onehot_low() - active-low one-hot digit select for a scan index
// ---------------------------------------------------------------------------
package tube_pkg;

   typedef logic [1:0] scan_idx_t;

   localparam logic [7:0]  SEG_OFF  = 8'hFF;
   localparam logic [3:0]  SEL_OFF  = 4'hF;

   localparam logic [31:0] OFS_DATA = 32'h0000_0000;
   localparam logic [31:0] OFS_CTRL = 32'h0000_0004;

   // The bridge hands over word offset bit 2 as the single addr bit.
   localparam logic ADDR_DATA = OFS_DATA[2];
   localparam logic ADDR_CTRL = OFS_CTRL[2];

   // Entry n is the code for hex digit n (entry 15 is the leftmost element).
   localparam logic [15:0][7:0] SEG_CODE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [3:0] sel_onehot_low(input scan_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/tube_driver_if.sv
// ---------------------------------------------------------------------------
// tube_driver_if
// Register bus between the CPU bridge and the tube driver.
//   we      - write strobe, valid this cycle
//   addr    - register select (0 = DATA, 1 = CTRL)
//   byteen  - byte-lane enables for the write
//   wdata   - write data
//   rdata   - combinational read of the register selected by addr
// Modports: master (bridge side), slave (peripheral side).
// ---------------------------------------------------------------------------
interface tube_driver_if;
   logic        we;
   logic        addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, output addr, output byteen, output wdata,
                   input  rdata);
   modport slave  (input  we, input  addr, input  byteen, input  wdata,
                   output rdata);
endinterface

// File: rtl/hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Combinational hex-digit to active-low seven-segment decoder, dp off.
//   hex - 4-bit digit value
//   seg - segments, bit 7 = dp, bits 6..0 = g..a, active-low
// ---------------------------------------------------------------------------
module hex_to_seg (
   input  logic [3:0] hex,
   output logic [7:0] seg
);
   import tube_pkg::*;

   assign seg = SEG_CODE[hex];

endmodule

// File: rtl/tube_driver.sv
// ---------------------------------------------------------------------------
// tube_driver
// Memory-mapped driver for two 4-digit common-anode seven-segment tubes.
// The CPU writes a 32-bit value to DATA; tube B shows DATA[31:16] and tube A
// shows DATA[15:0], one digit per scan slot, multiplexed onto active-low
// segment and select pins. CTRL[0] enables the display.
//
// Parameters:
//   SCAN_DIV - clock cycles each digit slot stays lit (>= 1)
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   bus        - register bus (tube_driver_if.slave)
//   seg_a/sel_a - low tube segments / digit selects, active-low, registered
//   seg_b/sel_b - high tube segments / digit selects, active-low, registered
// Build option:
//   TUBE_BLANK_EN - when defined, leading zeros of each tube are blanked
//                   (digit 0 is always shown).
// ---------------------------------------------------------------------------
module tube_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   tube_driver_if.slave bus,
   output logic [7:0]  seg_a,
   output logic [3:0]  sel_a,
   output logic [7:0]  seg_b,
   output logic [3:0]  sel_b
);
   import tube_pkg::*;

   localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [31:0]   data_q;
   logic          en_q;
   logic [PW-1:0] presc_q;
   scan_idx_t     scan_q;

   logic [15:0]   hw_a, hw_b;
   logic [3:0]    nib_a, nib_b;
   logic [7:0]    dec_a, dec_b;
   logic          blank_a, blank_b;

   // Register file: byte-lane writes into DATA, only bit 0 of lane 0 in CTRL.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         en_q   <= 1'b1;
      end else if (bus.we) begin
         if (bus.addr == ADDR_DATA) begin
            for (int i = 0; i < 4; i++) begin
               if (bus.byteen[i]) data_q[8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end else if (bus.byteen[0]) begin
            en_q <= bus.wdata[0];
         end
      end
   end

   always_comb begin
      bus.rdata = (bus.addr == ADDR_DATA) ? data_q : {31'b0, en_q};
   end

   // Scan timing: the digit index advances once per prescaler wrap and is
   // not disturbed by register writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         scan_q  <= '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_q <= '0;
         scan_q  <= scan_q + 2'd1;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign hw_a  = data_q[15:0];
   assign hw_b  = data_q[31:16];
   assign nib_a = hw_a[{scan_q, 2'b00} +: 4];
   assign nib_b = hw_b[{scan_q, 2'b00} +: 4];

   hex_to_seg u_dec_a (.hex(nib_a), .seg(dec_a));
   hex_to_seg u_dec_b (.hex(nib_b), .seg(dec_b));

`ifdef TUBE_BLANK_EN
   // A digit is a leading zero when it and every digit above it are zero.
   function automatic logic blank_digit(input logic [15:0] hw, input scan_idx_t idx);
      return (idx != 2'd0) && ((hw >> {idx, 2'b00}) == 16'h0000);
   endfunction

   assign blank_a = blank_digit(hw_a, scan_q);
   assign blank_b = blank_digit(hw_b, scan_q);
`else
   assign blank_a = 1'b0;
   assign blank_b = 1'b0;
`endif

   // Pin register: everything reaching the tubes is launched from here.
   always_ff @(posedge clk) begin
      if (reset || !en_q) begin
         seg_a <= SEG_OFF;
         sel_a <= SEL_OFF;
         seg_b <= SEG_OFF;
         sel_b <= SEL_OFF;
      end else begin
         seg_a <= blank_a ? SEG_OFF : dec_a;
         sel_a <= blank_a ? SEL_OFF : sel_onehot_low(scan_q);
         seg_b <= blank_b ? SEG_OFF : dec_b;
         sel_b <= blank_b ? SEL_OFF : sel_onehot_low(scan_q);
      end
   end

endmodule
